intf_or: RTL and testbench

- Handshaked 1-bit OR block with three method-style interfaces: action methods a and b, and actionvalue method y.
- Operands are queued in FIFO a and FIFO b. An internal rule pairs their heads in order and pushes (a OR b) into FIFO y.
- The consumer drains y with an enable/ready handshake.
- Used as a leaf compute block between ready/enable producers and consumers.

---
 rtl/intf_or.sv | 119 +++++++++++
 tb/tb_intf_or.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/intf_or.sv
// Handshaked 1-bit OR block: operands queue in FIFOs a and b, and a compute rule
// pairs their heads in order and pushes the OR result into FIFO y.

module intf_or_fifo #(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic not_full,
    output logic not_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what lets push and pop share a cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only ever read
    // after it has been written, and count gates the visible output.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign not_full  = (count != FULL_CNT);
    assign not_empty = (count != '0);
    assign dout      = not_empty ? mem[rd_ptr] : 1'b0;
endmodule

module intf_or #(
    parameter int A_DEPTH = 2,
    parameter int B_DEPTH = 1,
    parameter int Y_DEPTH = 3
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic a_data,
    input  logic a_en,
    output logic a_rdy,
    input  logic b_data,
    input  logic b_en,
    output logic b_rdy,
    input  logic y_en,
    output logic y_data,
    output logic y_rdy
);
    logic a_head;
    logic b_head;
    logic a_valid;
    logic b_valid;
    logic y_space;
    logic fire;

    // Rule decision uses registered occupancy only, so no enable reaches a ready.
    assign fire = a_valid & b_valid & y_space;

    intf_or_fifo #(.DEPTH(A_DEPTH)) u_fifo_a (
        .CLK       (CLK),
        .rst       (RST_N),
        .push      (a_en & a_rdy),
        .pop       (fire),
        .din       (a_data),
        .dout      (a_head),
        .not_full  (a_rdy),
        .not_empty (a_valid)
    );

    intf_or_fifo #(.DEPTH(B_DEPTH)) u_fifo_b (
        .CLK       (CLK),
        .rst       (RST_N),
        .push      (b_en & b_rdy),
        .pop       (fire),
        .din       (b_data),
        .dout      (b_head),
        .not_full  (b_rdy),
        .not_empty (b_valid)
    );

    intf_or_fifo #(.DEPTH(Y_DEPTH)) u_fifo_y (
        .CLK       (CLK),
        .rst       (RST_N),
        .push      (fire),
        .pop       (y_en & y_rdy),
        .din       (a_head | b_head),
        .dout      (y_data),
        .not_full  (y_space),
        .not_empty (y_rdy)
    );
endmodule

// File: tb/tb_intf_or.sv
// Directed self-checking bench for intf_or: reset, truth table, ordering,
// backpressure, ignored enables and mid-run reset.

module tb_intf_or;
    logic CLK = 1'b0;
    logic RST_N;
    logic a_data, a_en, a_rdy;
    logic b_data, b_en, b_rdy;
    logic y_en, y_data, y_rdy;

    int checks   = 0;
    int failures = 0;

    intf_or dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .a_data (a_data),
        .a_en   (a_en),
        .a_rdy  (a_rdy),
        .b_data (b_data),
        .b_en   (b_en),
        .b_rdy  (b_rdy),
        .y_en   (y_en),
        .y_data (y_data),
        .y_rdy  (y_rdy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_en = 1'b0; a_data = 1'b0;
        b_en = 1'b0; b_data = 1'b0;
        y_en = 1'b0;
    endtask

    logic [3:0] tt_a   = 4'b1100;
    logic [3:0] tt_b   = 4'b1010;
    logic [3:0] tt_exp = 4'b1110;

    initial begin
        idle_inputs();
        RST_N = 1'b1;

        // Reset held two cycles
        tick();
        tick();
        RST_N = 1'b0;
        check("reset_a_rdy", a_rdy, 1'b1);
        check("reset_b_rdy", b_rdy, 1'b1);
        check("reset_y_rdy", y_rdy, 1'b0);
        check("reset_y_data", y_data, 1'b0);

        // Truth table: pairs (0,0),(0,1),(1,0),(1,1)
        for (int i = 0; i < 4; i++) begin
            a_en = 1'b1; a_data = tt_a[i];
            b_en = 1'b1; b_data = tt_b[i];
            tick();
            idle_inputs();
            check($sformatf("tt%0d_y_rdy_early", i), y_rdy, 1'b0);
            tick();
            check($sformatf("tt%0d_y_rdy", i), y_rdy, 1'b1);
            check($sformatf("tt%0d_y_data", i), y_data, tt_exp[i]);
            y_en = 1'b1;
            tick();
            y_en = 1'b0;
            check($sformatf("tt%0d_y_drained", i), y_rdy, 1'b0);
        end

        // Ordering with skew: a=1, a=0, then b=0, b=0
        a_en = 1'b1; a_data = 1'b1;
        tick();
        a_data = 1'b0;
        tick();
        a_en = 1'b0;
        check("ord_a_full", a_rdy, 1'b0);
        b_en = 1'b1; b_data = 1'b0;
        tick();
        check("ord_b_full", b_rdy, 1'b0);
        check("ord_y_empty", y_rdy, 1'b0);
        tick();
        check("ord_first_y_rdy", y_rdy, 1'b1);
        check("ord_first_y", y_data, 1'b1);
        check("ord_b_freed", b_rdy, 1'b1);
        tick();
        b_en = 1'b0;
        tick();
        check("ord_head_still_first", y_data, 1'b1);
        y_en = 1'b1;
        tick();
        check("ord_second_y_rdy", y_rdy, 1'b1);
        check("ord_second_y", y_data, 1'b0);
        tick();
        y_en = 1'b0;
        check("ord_drained", y_rdy, 1'b0);
        check("ord_a_empty", a_rdy, 1'b1);

        // Backpressure: stream a=b=1 without draining y
        a_en = 1'b1; a_data = 1'b1;
        b_en = 1'b1; b_data = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("bp_y_rdy", y_rdy, 1'b1);
        check("bp_y_data", y_data, 1'b1);
        check("bp_a_rdy", a_rdy, 1'b0);
        check("bp_b_rdy", b_rdy, 1'b0);

        // Ignored enable: b_en with b_data=0 while b is full
        a_en = 1'b0;
        b_data = 1'b0;
        tick();
        b_en = 1'b0;
        check("ign_b_rdy", b_rdy, 1'b0);

        // One dequeue frees y; rule fires the following edge
        y_en = 1'b1;
        tick();
        y_en = 1'b0;
        check("bp_pop_a_rdy", a_rdy, 1'b0);
        check("bp_pop_b_rdy", b_rdy, 1'b0);
        tick();
        check("bp_resume_a_rdy", a_rdy, 1'b1);
        check("bp_resume_b_rdy", b_rdy, 1'b1);

        // Three results remain, all from accepted (1,1) pairs
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_drain%0d_rdy", i), y_rdy, 1'b1);
            check($sformatf("bp_drain%0d_data", i), y_data, 1'b1);
            y_en = 1'b1;
            tick();
            y_en = 1'b0;
        end
        check("bp_drain_done", y_rdy, 1'b0);

        // Build partial state (y has 1 entry, a has 1 entry), then reset
        b_en = 1'b1; b_data = 1'b1;
        tick();
        b_en = 1'b0;
        tick();
        check("mid_y_rdy", y_rdy, 1'b1);
        a_en = 1'b1; a_data = 1'b1;
        tick();
        check("mid_y_pre_reset", y_rdy, 1'b1);
        a_en = 1'b1; a_data = 1'b1;
        b_en = 1'b1; b_data = 1'b1;
        RST_N = 1'b1;
        tick();
        RST_N = 1'b0;
        idle_inputs();
        check("mid_reset_a_rdy", a_rdy, 1'b1);
        check("mid_reset_b_rdy", b_rdy, 1'b1);
        check("mid_reset_y_rdy", y_rdy, 1'b0);
        check("mid_reset_y_data", y_data, 1'b0);
        tick();
        check("mid_reset_stays_empty", y_rdy, 1'b0);

        // Fresh pair (0,1) after reset
        a_en = 1'b1; a_data = 1'b0;
        b_en = 1'b1; b_data = 1'b1;
        tick();
        idle_inputs();
        tick();
        check("post_reset_y_rdy", y_rdy, 1'b1);
        check("post_reset_y_data", y_data, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
